// File: rtl/spi_fifo_buffer.sv
// Circular FIFO between the SPI serialiser and the processor data bus.
// Independent read/write pointers, occupancy count, sticky overflow/underflow
// flags, synchronous flush and a one-cycle read-valid strobe.
module spi_fifo_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BUF_SIZE   = 10
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 wr,
  input  logic [DATA_WIDTH-1:0]                data_in,
  input  logic                                 oe,
  output logic [DATA_WIDTH-1:0]                data_out,
  output logic                                 data_valid,
  input  logic                                 flush,
  output logic [$clog2(BUF_SIZE+1)-1:0]        count,
  output logic                                 empty,
  output logic                                 full,
  output logic                                 overflow,
  output logic                                 underflow
);

  localparam int unsigned ADDR_WIDTH = $clog2(BUF_SIZE);
  localparam int unsigned CNT_WIDTH  = $clog2(BUF_SIZE + 1);

  logic [DATA_WIDTH-1:0] mem_q [BUF_SIZE];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic full_w, empty_w;
  logic wr_accept, rd_accept;

  assign full_w  = (count_q == CNT_WIDTH'(BUF_SIZE));
  assign empty_w = (count_q == '0);

  // A full FIFO still accepts a write when a read frees the slot in the same cycle.
  assign wr_accept = wr & (~full_w | oe) & ~flush;
  assign rd_accept = oe & ~empty_w & ~flush;

  // Next-state for pointers, occupancy, read data and status flags.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    ovf_d      = ovf_q;
    udf_d      = udf_q;

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      data_out_d = '0;
      ovf_d      = 1'b0;
      udf_d      = 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr_d = (wr_ptr_q == ADDR_WIDTH'(BUF_SIZE - 1)) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
      end else if (wr) begin
        ovf_d = 1'b1;
      end

      if (rd_accept) begin
        // Memory is read before this edge's write lands, so a full wr+oe returns the oldest word.
        data_out_d = mem_q[rd_ptr_q];
        valid_d    = 1'b1;
        rd_ptr_d   = (rd_ptr_q == ADDR_WIDTH'(BUF_SIZE - 1)) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);
      end else if (oe) begin
        udf_d = 1'b1;
      end

      if (wr_accept && !rd_accept) begin
        count_d = count_q + CNT_WIDTH'(1);
      end else if (rd_accept && !wr_accept) begin
        count_d = count_q - CNT_WIDTH'(1);
      end
    end
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // Storage array; contents are deliberately left uninitialised on reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = valid_q;
  assign count      = count_q;
  assign empty      = empty_w;
  assign full       = full_w;
  assign overflow   = ovf_q;
  assign underflow  = udf_q;

endmodule
